// File: rtl/branch_ctrl.sv
// branch_ctrl: 2-bit counter branch predictor with EX-stage resolution, flush/redirect and statistics
module branch_ctrl #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             ex_branch,
  input  logic             ex_stall,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             jump_taken,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam logic RUN    = 1'b0;
  localparam logic SHADOW = 1'b1;
  logic [1:0] tbl [2**IDX_W];
  logic state;
  logic resolve;
  logic mispredict;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0] cur;
  logic [1:0] nxt;
  logic unused_pc;
  assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[1:0]};
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign pred_taken = tbl[if_pc[IDX_W+1:2]][1];
  always_comb begin
    resolve = ex_branch && !ex_stall && state == RUN && !rst;
    mispredict = resolve && (jump_taken != ex_pred_taken);
    flush = mispredict;
    redirect_valid = mispredict;
    redirect_pc = mispredict ? (jump_taken ? ex_target : ex_pc + PC_W'(4)) : '0;
    cur = tbl[ex_idx];
    nxt = jump_taken ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= 2'b01;
      state <= RUN;
      branch_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      state <= mispredict ? SHADOW : RUN;
      if (resolve) begin
        tbl[ex_idx] <= nxt;
        if (~&branch_cnt) branch_cnt <= branch_cnt + CNT_W'(1);
        if (mispredict && ~&mispred_cnt) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scoreboard-driven directed checks of branch_ctrl against a behavioural model
module tb_branch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_branch;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        jump_taken;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  logic [1:0] mt [16];
  int mbc;
  int mmc;
  bit msh;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_branch(ex_branch), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .jump_taken(jump_taken), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mt[i] = 2'b01;
    mbc = 0;
    mmc = 0;
    msh = 1'b0;
  endtask

  task automatic cyc(input logic br, input logic st, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic pt, input logic jt);
    logic res;
    logic mis;
    logic [31:0] rp;
    logic [3:0] i;
    @(negedge clk);
    ex_branch = br;
    ex_stall = st;
    ex_pc = pc;
    ex_target = tgt;
    ex_pred_taken = pt;
    jump_taken = jt;
    if_pc = pc;
    res = br && !st && !msh;
    mis = res && (jt != pt);
    rp = mis ? (jt ? tgt : pc + 32'd4) : 32'd0;
    i = pc[5:2];
    push("flush", {31'b0, mis});
    push("redirect_valid", {31'b0, mis});
    push("redirect_pc", rp);
    push("pred_taken_pre", {31'b0, mt[i][1]});
    #1;
    chk({31'b0, flush});
    chk({31'b0, redirect_valid});
    chk(redirect_pc);
    chk({31'b0, pred_taken});
    if (res) begin
      mt[i] = jt ? (mt[i] == 2'd3 ? 2'd3 : mt[i] + 2'd1) : (mt[i] == 2'd0 ? 2'd0 : mt[i] - 2'd1);
      mbc++;
      if (mis) mmc++;
    end
    msh = mis;
    @(posedge clk);
    #1;
    push("branch_cnt", 32'(mbc));
    push("mispred_cnt", 32'(mmc));
    push("pred_taken_post", {31'b0, mt[i][1]});
    chk({16'b0, branch_cnt});
    chk({16'b0, mispred_cnt});
    chk({31'b0, pred_taken});
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    ex_branch = 1'b0;
    ex_stall = 1'b0;
    ex_pc = 32'h0;
    ex_target = 32'h0;
    ex_pred_taken = 1'b0;
    jump_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    push("reset_pred", 32'd0);
    push("reset_branch_cnt", 32'd0);
    push("reset_mispred_cnt", 32'd0);
    push("reset_flush", 32'd0);
    chk({31'b0, pred_taken});
    chk({16'b0, branch_cnt});
    chk({16'b0, mispred_cnt});
    chk({31'b0, flush});

    cyc(1, 0, 32'h100, 32'h80, 0, 1);
    push("first_mis_pred_now_taken", 32'd1);
    chk({31'b0, pred_taken});
    cyc(0, 0, 32'h100, 32'h0, 0, 0);
    repeat (3) cyc(1, 0, 32'h100, 32'h80, 1, 1);
    cyc(1, 0, 32'h100, 32'h80, 1, 0);
    push("saturated_then_nt_pred", 32'd1);
    chk({31'b0, pred_taken});
    cyc(0, 0, 32'h100, 32'h0, 0, 0);

    repeat (3) cyc(1, 1, 32'h200, 32'h300, 0, 1);
    cyc(1, 0, 32'h200, 32'h300, 0, 1);
    cyc(0, 0, 32'h200, 32'h0, 0, 0);

    cyc(1, 0, 32'h40, 32'h10, 0, 1);
    cyc(1, 0, 32'h40, 32'h10, 0, 1);
    cyc(1, 0, 32'h40, 32'h10, 0, 1);
    cyc(0, 0, 32'h40, 32'h0, 0, 0);

    cyc(1, 0, 32'h44, 32'h8, 0, 0);
    cyc(1, 0, 32'h44, 32'h8, 0, 1);
    cyc(0, 0, 32'h44, 32'h0, 0, 0);

    @(negedge clk);
    ex_branch = 1'b1;
    ex_stall = 1'b0;
    ex_pc = 32'hFFFF_FFFC;
    ex_target = 32'h1234;
    ex_pred_taken = 1'b1;
    jump_taken = 1'b0;
    if_pc = 32'hFFFF_FFFC;
    #1;
    push("wrap_flush", 32'd1);
    push("wrap_redirect_pc", 32'd0);
    chk({31'b0, flush});
    chk(redirect_pc);
    rst = 1'b1;
    #1;
    model_reset();
    push("rst_flush", 32'd0);
    push("rst_redirect_valid", 32'd0);
    push("rst_branch_cnt", 32'd0);
    push("rst_mispred_cnt", 32'd0);
    chk({31'b0, flush});
    chk({31'b0, redirect_valid});
    chk({16'b0, branch_cnt});
    chk({16'b0, mispred_cnt});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ex_branch = 1'b0;
    if_pc = 32'h100;
    #1;
    push("post_rst_pred_100", 32'd0);
    chk({31'b0, pred_taken});
    cyc(1, 0, 32'h100, 32'h80, 0, 1);
    cyc(0, 0, 32'h100, 32'h0, 0, 0);
    cyc(1, 0, 32'hFFFF_FFFC, 32'h20, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
